fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised multi-lane instruction fetch queue between the IF and ID stages of the pipelined MIPS core. It accepts up to FETCH_W instructions per cycle from the instruction memory, each tagged with its PC. It presents the oldest ISSUE_W entries to ID for dual- or wider issue. It honours FREEZE (memory stall) and FLUSH (taken branch / SYS redirect). It generalises the single-instruction IF/ID pipeline register to variable width, depth and per-lane occupancy.

## Interface
- DEPTH, 8, queue entries; power of two, >= FETCH_W + ISSUE_W
- FETCH_W, 2, instructions accepted per cycle
- ISSUE_W, 2, instructions presented per cycle
- IW, 32, instruction width
- CW, derived: $clog2(DEPTH+1); FC/IC derived: $clog2(FETCH_W+1) / $clog2(ISSUE_W+1)

- CLK  in  1  clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high
- FREEZE  in  1  global stall; holds all state
- FLUSH  in  1  discard all entries; overrides FREEZE
- push_valid  in  1  fetch group present
- push_count  in  FC  valid lanes in group, 0..FETCH_W; lanes 0..push_count-1 used
- push_instr  in  FETCH_W*IW  lane 0 in LSBs, lane 0 oldest
- push_pc  in  32  PC of lane 0; lane k PC = push_pc + 4k (mod 2^32)
- push_ready  out  1  free entries >= FETCH_W
- pop_count  in  IC  entries consumed by ID this cycle
- issue_valid  out  ISSUE_W  bit k = count > k
- issue_instr  out  ISSUE_W*IW  lane k = k-th oldest entry; 32'h0 (NOP) when invalid
- issue_pc  out  ISSUE_W*32  PC of lane k; 0 when invalid
- count  out  CW  occupied entries, 0..DEPTH

## Operation
- Storage: DEPTH x (IW instr + 32 PC), circular; rd_ptr, wr_ptr modulo DEPTH; count register.
- Push accept = push_valid & push_ready & !FREEZE & !FLUSH. It writes lanes 0..push_count-1 at wr_ptr+k and advances wr_ptr by push_count. It is all-or-nothing; no partial group acceptance.
- push_count > FETCH_W is illegal. It is treated as FETCH_W.
- Pop = !FREEZE & !FLUSH. Effective pop = min(pop_count, count). rd_ptr advances by effective pop.
- count_next = count + accepted push - effective pop. Simultaneous push and pop are both honoured in the same cycle.
- push_ready is computed from current count only. Pops in the same cycle do not raise it (no bypass).
- FLUSH: rd_ptr, wr_ptr and count go to 0 next edge. Same-cycle push and pop are discarded.
- FREEZE without FLUSH: pointers, count and storage are unchanged. Outputs are stable.
- Wrap-around: lanes straddling DEPTH-1 -> 0 are written and read contiguously modulo DEPTH.
- Full (count = DEPTH): push_ready = 0. Empty: issue_valid = 0; all lanes are NOP/0.
- No internal state machine beyond pointers and count. Occupancy states are EMPTY (count=0), PARTIAL, and BLOCKED (count > DEPTH-FETCH_W, push_ready=0).

## Timing
- Reset values: count 0, pointers 0, issue_valid 0, issue_instr 0, issue_pc 0, push_ready 1. Storage contents are don't-care.
- RESET has priority over FLUSH and FREEZE.
- Issue outputs are combinational from registered pointers, storage and count. They have no dependency on same-cycle push inputs.
- Push-to-issue latency is 1 cycle: an entry written at edge N is visible on issue lanes after edge N.
- Pop takes effect at the edge. The next-oldest entries appear on lane 0 after that edge.
- RESET or FLUSH mid-group: the whole in-flight group is lost. push_ready is 1 the following cycle.

## Test plan
- Reset, then idle -> count 0, issue_valid 2'b00, issue_instr 0, push_ready 1.
- Push {0x8C220004, 0x00221820} at pc 0x400, count 2, no pop -> next cycle count 2, issue_valid 2'b11, issue_pc {0x404, 0x400}.
- Fill to DEPTH=8 with four 2-wide pushes and no pops -> push_ready 0. A fifth push with push_valid=1 is ignored and count stays 8. Then pop 2 -> push_ready 1 one cycle later.
- Steady state with push 2 / pop 2 every cycle for 20 cycles starting at pc 0x0 -> count constant, wrap-around exercised, issue_pc sequence strictly +4 with no gaps.
- Count 5, then FREEZE=1 for 3 cycles with push_valid=1 and pop_count=2 -> count 5 and outputs unchanged. Then FLUSH=1 with FREEZE=1 -> count 0, issue_valid 0.
- Count 1, push_count 1 at pc 0x1000, pop_count 2 -> effective pop 1, count 1, lane 0 pc 0x1000, issue_valid 2'b01.

Source files
------------

// File: rtl/fetch_queue.sv
// Multi-lane instruction fetch queue between IF and ID: accepts up to FETCH_W
// PC-tagged instructions per cycle and presents the oldest ISSUE_W entries.
module fetch_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned IW      = 32,
  localparam int unsigned CW     = $clog2(DEPTH + 1),
  localparam int unsigned FC     = $clog2(FETCH_W + 1),
  localparam int unsigned IC     = $clog2(ISSUE_W + 1)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    FREEZE,
  input  logic                    FLUSH,
  input  logic                    push_valid,
  input  logic [FC-1:0]           push_count,
  input  logic [FETCH_W*IW-1:0]   push_instr,
  input  logic [31:0]             push_pc,
  output logic                    push_ready,
  input  logic [IC-1:0]           pop_count,
  output logic [ISSUE_W-1:0]      issue_valid,
  output logic [ISSUE_W*IW-1:0]   issue_instr,
  output logic [ISSUE_W*32-1:0]   issue_pc,
  output logic [CW-1:0]           count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IW-1:0] mem_instr_q [DEPTH];
  logic [31:0]   mem_pc_q    [DEPTH];

  logic          push_accept;
  logic [FC-1:0] push_n;
  logic [CW-1:0] pop_req;
  logic [CW-1:0] pop_eff;

  // Readiness looks only at current occupancy; same-cycle pops do not bypass.
  assign push_ready = (count_q <= CW'(DEPTH - FETCH_W));
  assign count      = count_q;

  always_comb begin
    push_n      = (push_count > FC'(FETCH_W)) ? FC'(FETCH_W) : push_count;
    push_accept = push_valid & push_ready & ~FREEZE & ~FLUSH;
    pop_req     = CW'(pop_count);
    pop_eff     = '0;
    if (!FREEZE && !FLUSH) begin
      pop_eff = (pop_req > count_q) ? count_q : pop_req;
    end

    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (FLUSH) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else if (!FREEZE) begin
      count_d  = count_q - pop_eff + (push_accept ? CW'(push_n) : CW'(0));
      rd_ptr_d = rd_ptr_q + PW'(pop_eff);
      wr_ptr_d = wr_ptr_q + (push_accept ? PW'(push_n) : PW'(0));
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage has no reset; lanes past the array end wrap through pointer truncation.
  always_ff @(posedge CLK) begin
    if (!RESET && push_accept) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (FC'(k) < push_n) begin
          mem_instr_q[wr_ptr_q + PW'(k)] <= push_instr[k*IW +: IW];
          mem_pc_q[wr_ptr_q + PW'(k)]    <= push_pc + 32'(4 * k);
        end
      end
    end
  end

  always_comb begin
    issue_valid = '0;
    issue_instr = '0;
    issue_pc    = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (count_q > CW'(k)) begin
        issue_valid[k]         = 1'b1;
        issue_instr[k*IW +: IW] = mem_instr_q[rd_ptr_q + PW'(k)];
        issue_pc[k*32 +: 32]   = mem_pc_q[rd_ptr_q + PW'(k)];
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned FETCH_W = 2;
  localparam int unsigned ISSUE_W = 2;
  localparam int unsigned IW      = 32;

  logic        CLK = 1'b0;
  logic        RESET, FREEZE, FLUSH;
  logic        push_valid;
  logic [1:0]  push_count;
  logic [63:0] push_instr;
  logic [31:0] push_pc;
  logic        push_ready;
  logic [1:0]  pop_count;
  logic [1:0]  issue_valid;
  logic [63:0] issue_instr;
  logic [63:0] issue_pc;
  logic [3:0]  count;

  fetch_queue #(
    .DEPTH  (DEPTH),
    .FETCH_W(FETCH_W),
    .ISSUE_W(ISSUE_W),
    .IW     (IW)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .FREEZE     (FREEZE),
    .FLUSH      (FLUSH),
    .push_valid (push_valid),
    .push_count (push_count),
    .push_instr (push_instr),
    .push_pc    (push_pc),
    .push_ready (push_ready),
    .pop_count  (pop_count),
    .issue_valid(issue_valid),
    .issue_instr(issue_instr),
    .issue_pc   (issue_pc),
    .count      (count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t model_q[$];
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: FIFO of entries; pops come off the front of the pre-edge contents.
  task automatic model_update(input logic pv, input int pcnt, input logic [63:0] instr,
                              input logic [31:0] pc, input int pop, input logic frz,
                              input logic fl, input logic rst);
    int n;
    int e;
    bit ready;
    if (rst || fl) begin
      model_q.delete();
    end else if (!frz) begin
      ready = (model_q.size() <= DEPTH - FETCH_W);
      n = (pcnt > FETCH_W) ? FETCH_W : pcnt;
      e = (pop > model_q.size()) ? model_q.size() : pop;
      for (int i = 0; i < e; i++) void'(model_q.pop_front());
      if (pv && ready) begin
        for (int k = 0; k < n; k++) begin
          entry_t ent;
          ent.instr = instr[k*32 +: 32];
          ent.pc    = pc + 32'(4 * k);
          model_q.push_back(ent);
        end
      end
    end
  endtask

  task automatic check_all();
    logic [1:0]  exp_valid;
    logic [63:0] exp_instr;
    logic [63:0] exp_pc;
    exp_valid = '0;
    exp_instr = '0;
    exp_pc    = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (k < model_q.size()) begin
        exp_valid[k]         = 1'b1;
        exp_instr[k*32 +: 32] = model_q[k].instr;
        exp_pc[k*32 +: 32]   = model_q[k].pc;
      end
    end
    check("count", 128'(count), 128'(model_q.size()));
    check("push_ready", 128'(push_ready), 128'(model_q.size() <= DEPTH - FETCH_W));
    check("issue_valid", 128'(issue_valid), 128'(exp_valid));
    check("issue_instr", 128'(issue_instr), 128'(exp_instr));
    check("issue_pc", 128'(issue_pc), 128'(exp_pc));
  endtask

  task automatic step(input logic pv, input int pcnt, input logic [63:0] instr,
                      input logic [31:0] pc, input int pop, input logic frz,
                      input logic fl, input logic rst);
    push_valid = pv;
    push_count = 2'(pcnt);
    push_instr = instr;
    push_pc    = pc;
    pop_count  = 2'(pop);
    FREEZE     = frz;
    FLUSH      = fl;
    RESET      = rst;
    @(posedge CLK);
    model_update(pv, pcnt, instr, pc, pop, frz, fl, rst);
    #1;
    check_all();
  endtask

  logic [1:0]  snap_valid;
  logic [63:0] snap_pc;

  initial begin
    RESET = 1'b1; FREEZE = 1'b0; FLUSH = 1'b0; push_valid = 1'b0;
    push_count = '0; push_instr = '0; push_pc = '0; pop_count = '0;
    #1;

    // Reset then idle.
    step(0, 0, 64'h0, 32'h0, 0, 0, 0, 1);
    step(0, 0, 64'h0, 32'h0, 0, 0, 0, 0);
    check("reset_issue_instr", 128'(issue_instr), 128'h0);
    check("reset_push_ready", 128'(push_ready), 128'h1);

    // First two-wide group.
    step(1, 2, {32'h8C220004, 32'h00221820}, 32'h400, 0, 0, 0, 0);
    check("first_issue_pc", 128'(issue_pc), 128'h00000404_00000400);
    check("first_issue_valid", 128'(issue_valid), 128'h3);

    // Fill to full, overflow attempt, then pop two.
    for (int i = 1; i < 4; i++)
      step(1, 2, {$urandom, $urandom}, 32'h400 + 32'(8 * i), 0, 0, 0, 0);
    check("full_push_ready", 128'(push_ready), 128'h0);
    step(1, 2, {$urandom, $urandom}, 32'h500, 0, 0, 0, 0);
    check("full_count", 128'(count), 128'h8);
    step(0, 0, 64'h0, 32'h0, 2, 0, 0, 0);
    check("after_pop_ready", 128'(push_ready), 128'h1);

    // Steady push 2 / pop 2 from pc 0, crossing the wrap point.
    step(0, 0, 64'h0, 32'h0, 0, 0, 1, 0);
    step(1, 2, {$urandom, $urandom}, 32'h0, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      step(1, 2, {$urandom, $urandom}, 32'(8 * i), 2, 0, 0, 0);
      check("steady_lane0_pc", 128'(issue_pc[31:0]), 128'(8 * i));
    end

    // Count 5, freeze holds everything, then flush overrides freeze.
    step(0, 0, 64'h0, 32'h0, 0, 0, 1, 0);
    step(1, 2, {$urandom, $urandom}, 32'h100, 0, 0, 0, 0);
    step(1, 2, {$urandom, $urandom}, 32'h108, 0, 0, 0, 0);
    step(1, 1, {$urandom, $urandom}, 32'h110, 0, 0, 0, 0);
    snap_valid = issue_valid;
    snap_pc    = issue_pc;
    for (int i = 0; i < 3; i++) begin
      step(1, 2, {$urandom, $urandom}, 32'h200, 2, 1, 0, 0);
      check("freeze_count", 128'(count), 128'h5);
      check("freeze_issue_pc", 128'(issue_pc), 128'(snap_pc));
    end
    step(1, 2, {$urandom, $urandom}, 32'h200, 2, 1, 1, 0);
    check("flush_count", 128'(count), 128'h0);
    check("flush_valid", 128'(issue_valid), 128'h0);

    // Over-pop clamps to occupancy while a push lands in the same cycle.
    step(1, 1, {$urandom, $urandom}, 32'h2000, 0, 0, 0, 0);
    step(1, 1, {$urandom, $urandom}, 32'h1000, 2, 0, 0, 0);
    check("overpop_count", 128'(count), 128'h1);
    check("overpop_pc", 128'(issue_pc[31:0]), 128'h1000);
    check("overpop_valid", 128'(issue_valid), 128'h1);

    // Random traffic, including illegal push_count 3 and occasional reset/flush.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3), {$urandom, $urandom},
           $urandom, $urandom_range(0, 2), $urandom_range(0, 9) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
